fft_bf_scheduler: RTL and testbench

Control sequencer for the resource-shared radix-2 DIT butterfly in the Shared Butterfly FFT. It walks all log2(N) stages of an in-place N-point FFT over a ping-pong two-bank data memory. It issues one butterfly every 2 clocks, aligned to the butterfly's real/imag phase, and generates the read, twiddle and latency-compensated write addresses. Input data is already bit-reversed in bank 0 by the loader; this block does no data-path arithmetic.

---
 rtl/fft_bf_scheduler_if.sv | 34 +++
 rtl/fft_bf_scheduler.sv | 172 +++++++++++++++++
 tb/tb_fft_bf_scheduler.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_bf_scheduler_if.sv
// Control bus between the shared-butterfly scheduler and the FFT data path.
// master: driven by the scheduler (takes start, drives strobes, addresses, banks, status).
// slave : the data path / controller side (drives start, observes everything else).
interface fft_bf_scheduler_if #(
  parameter int unsigned N_LOG2 = 4
);
  logic              start;
  logic              busy;
  logic              done;
  logic              bf_phase;
  logic              rd_en;
  logic [N_LOG2-1:0] rd_addr0;
  logic [N_LOG2-1:0] rd_addr1;
  logic              rd_bank;
  logic [N_LOG2-2:0] tw_addr;
  logic              wr_en;
  logic [N_LOG2-1:0] wr_addr0;
  logic [N_LOG2-1:0] wr_addr1;
  logic              wr_bank;
  logic [3:0]        stage;
  logic              result_bank;

  modport master (
    input  start,
    output busy, done, bf_phase, rd_en, rd_addr0, rd_addr1, rd_bank, tw_addr,
           wr_en, wr_addr0, wr_addr1, wr_bank, stage, result_bank
  );

  modport slave (
    output start,
    input  busy, done, bf_phase, rd_en, rd_addr0, rd_addr1, rd_bank, tw_addr,
           wr_en, wr_addr0, wr_addr1, wr_bank, stage, result_bank
  );
endinterface

// File: rtl/fft_bf_scheduler.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT over a ping-pong
// two-bank memory. Issues one butterfly every two clocks on bf_phase=0, produces
// read/twiddle addresses and replays them as write addresses D cycles later.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-low reset
//   bus  - fft_bf_scheduler_if.master: start in; busy/done, bf_phase, rd_*, tw_addr,
//          wr_*, stage, result_bank out
module fft_bf_scheduler #(
  parameter int unsigned N_LOG2     = 4,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned BF_LATENCY = 4
) (
  input logic               clk,
  input logic               rst,
  fft_bf_scheduler_if.master bus
);
  localparam int unsigned D  = RD_LATENCY + BF_LATENCY;
  localparam int unsigned JW = N_LOG2 - 1;
  localparam logic [JW-1:0] J_LAST = '1;
  localparam logic [3:0]    S_LAST = 4'(N_LOG2 - 1);
  localparam logic [D-1:0]  TAP    = D'(1) << (D - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        stage_q, stage_d;
  logic [JW-1:0]     j_q, j_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              phase_q;
  logic              rd_en_q, rd_en_d;
  logic              wr_bank_q, wr_bank_d;
  logic [N_LOG2-1:0] ra0_q, ra0_d, ra1_q, ra1_d;
  logic [JW-1:0]     tw_q, tw_d;
  logic [D-1:0]      vld_q;
  logic [N_LOG2-1:0] a0_pipe [D];
  logic [N_LOG2-1:0] a1_pipe [D];

  logic              iss;
  logic [3:0]        iss_stage;
  logic [JW-1:0]     iss_j;
  logic              pending;
  logic [N_LOG2-1:0] jj, half, k, g, a0;

  // Any write still to come after the next edge (the tap itself is the current write).
  assign pending = rd_en_q | (|(vld_q & ~TAP));

  // Next-state, issue decision and address generation.
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    j_d       = j_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    iss       = 1'b0;
    iss_stage = stage_q;
    iss_j     = j_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_ISSUE;
          stage_d   = '0;
          j_d       = '0;
          busy_d    = 1'b1;
          iss_stage = '0;
          iss_j     = '0;
          iss       = phase_q;
        end
      end
      S_ISSUE: begin
        iss = phase_q;
      end
      S_DRAIN: begin
        if (!pending) begin
          if (stage_q != S_LAST) begin
            state_d   = S_ISSUE;
            stage_d   = stage_q + 4'd1;
            j_d       = '0;
            iss_stage = stage_q + 4'd1;
            iss_j     = '0;
            iss       = phase_q;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        stage_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Issuing happens when the coming cycle is bf_phase=0 (phase_q is 1 now).
    if (iss) begin
      j_d     = iss_j + JW'(1);
      state_d = (iss_j == J_LAST) ? S_DRAIN : S_ISSUE;
    end

    jj   = N_LOG2'(iss_j);
    half = N_LOG2'(1) << iss_stage;
    k    = jj & (half - N_LOG2'(1));
    g    = jj >> iss_stage;
    a0   = (g << (iss_stage + 4'd1)) + k;

    rd_en_d   = iss;
    ra0_d     = iss ? a0 : ra0_q;
    ra1_d     = iss ? (a0 + half) : ra1_q;
    tw_d      = iss ? JW'(k << (4'(N_LOG2 - 1) - iss_stage)) : tw_q;
    wr_bank_d = (state_d != S_IDLE) ? ~stage_d[0] : 1'b0;
  end

  // State, registered outputs and the write-replay pipeline.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      stage_q   <= '0;
      j_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      phase_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_bank_q <= 1'b0;
      ra0_q     <= '0;
      ra1_q     <= '0;
      tw_q      <= '0;
      vld_q     <= '0;
      for (int i = 0; i < int'(D); i++) begin
        a0_pipe[i] <= '0;
        a1_pipe[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      j_q        <= j_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      phase_q    <= ~phase_q;
      rd_en_q    <= rd_en_d;
      wr_bank_q  <= wr_bank_d;
      ra0_q      <= ra0_d;
      ra1_q      <= ra1_d;
      tw_q       <= tw_d;
      vld_q      <= (vld_q << 1) | D'(rd_en_q);
      a0_pipe[0] <= ra0_q;
      a1_pipe[0] <= ra1_q;
      for (int i = 1; i < int'(D); i++) begin
        a0_pipe[i] <= a0_pipe[i-1];
        a1_pipe[i] <= a1_pipe[i-1];
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.bf_phase    = phase_q;
  assign bus.rd_en       = rd_en_q;
  assign bus.rd_addr0    = ra0_q;
  assign bus.rd_addr1    = ra1_q;
  assign bus.rd_bank     = stage_q[0];
  assign bus.tw_addr     = tw_q;
  assign bus.wr_en       = vld_q[D-1];
  assign bus.wr_addr0    = a0_pipe[D-1];
  assign bus.wr_addr1    = a1_pipe[D-1];
  assign bus.wr_bank     = wr_bank_q;
  assign bus.stage       = stage_q;
  assign bus.result_bank = 1'(N_LOG2 % 2);
endmodule

// File: tb/tb_fft_bf_scheduler.sv
// Scoreboard bench for fft_bf_scheduler: default instance (N=16, D=5) and a
// small instance (N=8, D=7). Expected issues are queued when start is driven.
module tb_fft_bf_scheduler;
  logic clk;
  logic rst;

  fft_bf_scheduler_if #(.N_LOG2(4)) ifa ();
  fft_bf_scheduler_if #(.N_LOG2(3)) ifb ();

  fft_bf_scheduler #(.N_LOG2(4), .RD_LATENCY(1), .BF_LATENCY(4)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  fft_bf_scheduler #(.N_LOG2(3), .RD_LATENCY(1), .BF_LATENCY(6)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  typedef struct { int cyc; int a0; int a1; int tw; int stg; } rd_t;
  typedef struct { int cyc; int a0; int a1; int bank; } wr_t;

  rd_t rdq_a[$];
  rd_t rdq_b[$];
  wr_t wrq_a[$];
  wr_t wrq_b[$];

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int rel_cyc      = 0;
  int exp_done_a   = -1;
  int exp_done_b   = -1;
  int done_seen_a  = 0;
  int done_seen_b  = 0;
  int last_done_a  = 0;
  logic rst_s      = 1'b0;
  logic ph_m       = 1'b0;
  logic prev_rd_a  = 1'b0;
  logic prev_rd_b  = 1'b0;
  logic prev_dn_a  = 1'b0;
  logic prev_dn_b  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index, sampled reset and the expected butterfly phase.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= rst;
    ph_m  <= rst ? ~ph_m : 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
    end
  endtask

  // Queue every butterfly of one transform; acc is the first cycle in ISSUE.
  task automatic push_xfer(input int sel, input int acc);
    int nl, n, d, t0, p, last, idx, half;
    rd_t e;
    nl   = (sel == 0) ? 4 : 3;
    d    = (sel == 0) ? 5 : 7;
    n    = 1 << nl;
    t0   = (((acc - rel_cyc) & 1) == 0) ? acc : acc + 1;
    last = 2 * (n / 2 - 1) + d;
    p    = last + 1 + ((last + 1) & 1);
    for (int s = 0; s < nl; s++) begin
      half = 1 << s;
      idx  = 0;
      for (int gg = 0; gg < n / (2 * half); gg++) begin
        for (int kk = 0; kk < half; kk++) begin
          e.cyc = t0 + s * p + 2 * idx;
          e.a0  = gg * 2 * half + kk;
          e.a1  = e.a0 + half;
          e.tw  = kk * (n / (2 * half));
          e.stg = s;
          if (sel == 0) rdq_a.push_back(e); else rdq_b.push_back(e);
          idx++;
        end
      end
    end
    if (sel == 0) exp_done_a = t0 + (nl - 1) * p + last + 1;
    else          exp_done_b = t0 + (nl - 1) * p + last + 1;
  endtask

  task automatic wait_done(input int sel, input int n);
    int b = 0;
    while (((sel == 0) ? done_seen_a : done_seen_b) < n && b < 400) begin
      @(negedge clk);
      b++;
    end
    chk((sel == 0) ? "done_wait_a" : "done_wait_b",
        (sel == 0) ? done_seen_a : done_seen_b, n);
  endtask

  // Monitor / scoreboard for the default instance.
  always @(negedge clk) begin
    rd_t e;
    wr_t w;
    chk("phase_a", ifa.bf_phase, ph_m);
    if (!rst_s) begin
      chk("rst_rd_en_a", ifa.rd_en, 0);
      chk("rst_wr_en_a", ifa.wr_en, 0);
      chk("rst_done_a", ifa.done, 0);
      chk("rst_busy_a", ifa.busy, 0);
      chk("rst_stage_a", ifa.stage, 0);
      chk("rst_addr_a", {ifa.rd_addr0, ifa.rd_addr1, ifa.wr_addr0, ifa.wr_addr1, ifa.tw_addr}, 0);
      rdq_a.delete();
      wrq_a.delete();
      exp_done_a = -1;
      prev_rd_a  = 1'b0;
      prev_dn_a  = 1'b0;
    end else begin
      if (ifa.rd_en) begin
        chk("rd_adjacent_a", prev_rd_a, 0);
        if (rdq_a.size() == 0) chk("rd_unexpected_a", rdq_a.size(), 1);
        else begin
          e = rdq_a.pop_front();
          chk("rd_cycle_a", cyc, e.cyc);
          chk("rd_addr0_a", ifa.rd_addr0, e.a0);
          chk("rd_addr1_a", ifa.rd_addr1, e.a1);
          chk("tw_addr_a", ifa.tw_addr, e.tw);
          chk("stage_a", ifa.stage, e.stg);
          chk("rd_bank_a", ifa.rd_bank, e.stg & 1);
          chk("wr_bank_at_rd_a", ifa.wr_bank, (e.stg & 1) ^ 1);
          chk("busy_a", ifa.busy, 1);
          w.cyc = cyc + 5; w.a0 = e.a0; w.a1 = e.a1; w.bank = (e.stg & 1) ^ 1;
          wrq_a.push_back(w);
        end
      end
      if (ifa.wr_en) begin
        if (wrq_a.size() == 0) chk("wr_unexpected_a", wrq_a.size(), 1);
        else begin
          w = wrq_a.pop_front();
          chk("wr_cycle_a", cyc, w.cyc);
          chk("wr_addr0_a", ifa.wr_addr0, w.a0);
          chk("wr_addr1_a", ifa.wr_addr1, w.a1);
          chk("wr_bank_a", ifa.wr_bank, w.bank);
        end
      end
      if (prev_dn_a) chk("busy_after_done_a", ifa.busy, 0);
      if (ifa.done) begin
        chk("done_cycle_a", cyc, exp_done_a);
        exp_done_a  = -1;
        last_done_a = cyc;
        done_seen_a++;
      end
      prev_rd_a = ifa.rd_en;
      prev_dn_a = ifa.done;
    end
  end

  // Monitor / scoreboard for the small instance.
  always @(negedge clk) begin
    rd_t e;
    wr_t w;
    chk("phase_b", ifb.bf_phase, ph_m);
    if (!rst_s) begin
      chk("rst_rd_en_b", ifb.rd_en, 0);
      chk("rst_wr_en_b", ifb.wr_en, 0);
      chk("rst_busy_b", ifb.busy, 0);
      rdq_b.delete();
      wrq_b.delete();
      exp_done_b = -1;
      prev_rd_b  = 1'b0;
      prev_dn_b  = 1'b0;
    end else begin
      if (ifb.rd_en) begin
        chk("rd_adjacent_b", prev_rd_b, 0);
        if (rdq_b.size() == 0) chk("rd_unexpected_b", rdq_b.size(), 1);
        else begin
          e = rdq_b.pop_front();
          chk("rd_cycle_b", cyc, e.cyc);
          chk("rd_addr0_b", ifb.rd_addr0, e.a0);
          chk("rd_addr1_b", ifb.rd_addr1, e.a1);
          chk("tw_addr_b", ifb.tw_addr, e.tw);
          chk("rd_bank_b", ifb.rd_bank, e.stg & 1);
          w.cyc = cyc + 7; w.a0 = e.a0; w.a1 = e.a1; w.bank = (e.stg & 1) ^ 1;
          wrq_b.push_back(w);
        end
      end
      if (ifb.wr_en) begin
        if (wrq_b.size() == 0) chk("wr_unexpected_b", wrq_b.size(), 1);
        else begin
          w = wrq_b.pop_front();
          chk("wr_cycle_b", cyc, w.cyc);
          chk("wr_addr0_b", ifb.wr_addr0, w.a0);
          chk("wr_addr1_b", ifb.wr_addr1, w.a1);
          chk("wr_bank_b", ifb.wr_bank, w.bank);
        end
      end
      if (prev_dn_b) chk("busy_after_done_b", ifb.busy, 0);
      if (ifb.done) begin
        chk("done_cycle_b", cyc, exp_done_b);
        exp_done_b = -1;
        done_seen_b++;
      end
      prev_rd_b = ifb.rd_en;
      prev_dn_b = ifb.done;
    end
  end

  initial begin
    int b;
    rst       = 1'b0;
    ifa.start = 1'b0;
    ifb.start = 1'b0;

    // Reset, then idle with start low.
    repeat (5) @(negedge clk);
    rst     = 1'b1;
    rel_cyc = cyc;
    repeat (50) @(negedge clk);
    chk("idle_busy_a", ifa.busy, 0);
    chk("idle_stage_a", ifa.stage, 0);
    chk("idle_rd_bank_a", ifa.rd_bank, 0);
    chk("idle_wr_bank_a", ifa.wr_bank, 0);
    chk("idle_addr_a", {ifa.rd_addr0, ifa.rd_addr1, ifa.tw_addr}, 0);
    chk("result_bank_a", ifa.result_bank, 0);
    chk("result_bank_b", ifb.result_bank, 1);
    chk("idle_busy_b", ifb.busy, 0);

    // Full default transform from a single-cycle start pulse.
    @(negedge clk);
    ifa.start = 1'b1;
    push_xfer(0, cyc + 1);
    @(negedge clk);
    ifa.start = 1'b0;
    wait_done(0, 1);

    // Parameter sweep instance.
    @(negedge clk);
    ifb.start = 1'b1;
    push_xfer(1, cyc + 1);
    @(negedge clk);
    ifb.start = 1'b0;
    wait_done(1, 1);

    // start held high: no retrigger before IDLE, then a second transform.
    @(negedge clk);
    ifa.start = 1'b1;
    push_xfer(0, cyc + 1);
    wait_done(0, 2);
    push_xfer(0, last_done_a + 2);
    repeat (4) @(negedge clk);
    ifa.start = 1'b0;
    wait_done(0, 3);

    // Abort in stage 2, then restart from stage 0.
    @(negedge clk);
    ifa.start = 1'b1;
    push_xfer(0, cyc + 1);
    @(negedge clk);
    ifa.start = 1'b0;
    b = 0;
    while (!(ifa.rd_en === 1'b1 && ifa.stage == 4'd2) && b < 300) begin
      @(negedge clk);
      b++;
    end
    chk("abort_stage_a", ifa.stage, 2);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst     = 1'b1;
    rel_cyc = cyc;
    repeat (20) @(negedge clk);
    chk("abort_busy_a", ifa.busy, 0);
    chk("abort_stage0_a", ifa.stage, 0);
    chk("abort_rdq_a", rdq_a.size(), 0);
    @(negedge clk);
    ifa.start = 1'b1;
    push_xfer(0, cyc + 1);
    @(negedge clk);
    ifa.start = 1'b0;
    wait_done(0, 4);

    repeat (10) @(negedge clk);
    chk("left_rd_a", rdq_a.size(), 0);
    chk("left_wr_a", wrq_a.size(), 0);
    chk("left_rd_b", rdq_b.size(), 0);
    chk("left_wr_b", wrq_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
